// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// One iteration per clock: 32 RUN cycles, then one FIN cycle for sign fixup.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        div_q;
    logic        bz_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [31:0] a_q;
    logic [31:0] dv_q;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    logic [32:0] sum;
    logic [32:0] tmp;
    logic [31:0] rem;
    logic        ge;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    // Operand magnitudes; the sign is restored in FIN.
    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // acc holds {partial, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dv_q} : 33'd0);
        tmp = {acc_q[63:32], acc_q[31]};
        ge  = tmp >= {1'b0, dv_q};
        rem = ge ? 32'(tmp - {1'b0, dv_q}) : tmp[31:0];
        if (div_q) begin
            acc_d = {rem, acc_q[30:0], ge};
        end else begin
            acc_d = {sum, acc_q[31:1]};
        end
    end

    always_comb begin
        prod   = qneg_q ? -acc_q : acc_q;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_q) begin
            if (bz_q) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = qneg_q ? -acc_q[31:0] : acc_q[31:0];
                res_hi = rneg_q ? -acc_q[63:32] : acc_q[63:32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cnt_q == 5'd31) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            dv_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q  <= '0;
                        div_q  <= op[1];
                        bz_q   <= (b == 32'd0);
                        qneg_q <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        a_q    <= a;
                        dv_q   <= b_mag;
                        acc_q  <= {32'd0, a_mag};
                    end else begin
                        if (hi_we) hi_q <= a;
                        if (lo_we) lo_q <= a;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                end
                FIN: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit
// against a transaction-level arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    localparam logic [1:0] MULT  = 2'd0;
    localparam logic [1:0] MULTU = 2'd1;
    localparam logic [1:0] DIV   = 2'd2;
    localparam logic [1:0] DIVU  = 2'd3;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    task automatic tally(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tally(got === exp, $sformatf("%s: got %h, want %h", name, got, exp));
    endtask

    // Reference: what {hi,lo} must hold after an operation.
    function automatic logic [63:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MULT:  return 64'(sx * sy);
            MULTU: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Transaction model: an accepted op completes 33 edges later.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_res = 64'd0;
    bit          m_done = 1'b0;
    int          m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_done = 1'b0;
            m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_res = ref_res(op, a, b);
                m_rem = 33;
            end else begin
                if (hi_we) m_hi = a;
                if (lo_we) m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tally(busy === (m_rem > 0) && done === m_done &&
                  hi === m_hi && lo === m_lo,
                  $sformatf("cycle t=%0t busy %b/%b done %b/%b hi %h/%h lo %h/%h",
                            $time, busy, (m_rem > 0), done, m_done,
                            hi, m_hi, lo, m_lo));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic go(input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle.
    task automatic wait_done(input string name, input logic [31:0] eh,
                             input logic [31:0] el, input int lat);
        int k;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check({name, " latency"}, k, lat);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        go(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 33);
        go(MULT, -32'sd3, 32'sd5);
        wait_done("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        go(DIV, -32'sd7, 32'sd2);
        wait_done("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        go(DIVU, 32'd100, 32'd0);
        wait_done("divu by 0", 32'h0000_0064, 32'hFFFF_FFFF, 33);
        go(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div ovf", 32'd0, 32'h8000_0000, 33);

        @(posedge clk);
        #1 d0 = n_done;
        go(MULTU, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        op = MULTU;
        a = 32'd2;
        b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        hi_we = 1'b1;
        lo_we = 1'b1;
        a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done("busy ignore", 32'd0, 32'd42, 28);
        repeat (40) @(posedge clk);
        #1 check("one done pulse", n_done - d0, 1);

        hi_we = 1'b1;
        lo_we = 1'b1;
        a = 32'h1234_5678;
        @(posedge clk);
        #1 hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi", hi, 32'h1234_5678);
        check("mtlo", lo, 32'h1234_5678);
        start = 1'b1;
        hi_we = 1'b1;
        op = MULTU;
        a = 32'd3;
        b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        hi_we = 1'b0;
        check("start wins hi", hi, 32'h1234_5678);
        wait_done("start wins", 32'd0, 32'd9, 33);

        @(posedge clk);
        #1 go(DIVU, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 go(DIVU, 32'd17, 32'd5);
        wait_done("divu 17/5", 32'd2, 32'd3, 33);
        go(MULTU, 32'd4, 32'd4);
        wait_done("b2b multu", 32'd0, 32'd16, 33);

        @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 5) == 0;
            op = 2'($urandom);
            a = pick();
            b = pick();
            hi_we = ($urandom % 6) == 0;
            lo_we = ($urandom % 6) == 0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
